// File: rtl/gemm_drain_ctrl.sv
`default_nettype none
// =============================================================================
// gemm_drain_ctrl : shifts the PE accumulators out row by row into a small FIFO
//                   and streams them downstream with a valid/ready handshake.
// Revision        : 1.0
// =============================================================================
module gemm_drain_ctrl #(
  parameter int NumRows      = 4,
  parameter int NumCols      = 4,
  parameter int OutDataWidth = 32,
  localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        start_i,
  input  logic signed [NumCols-1:0][OutDataWidth-1:0] col_acc_i,
  output logic [1:0]                                  acc_mux_sel_o,
  output logic signed [NumCols-1:0][OutDataWidth-1:0] res_data_o,
  output logic [RW-1:0]                               res_row_o,
  output logic                                        res_valid_o,
  input  logic                                        res_ready_i,
  output logic                                        busy_o,
  output logic                                        done_o
);

  localparam int            CNT_W     = $clog2(NumRows + 1);
  localparam logic [RW-1:0] LAST_IDX  = RW'(NumRows - 1);
  localparam logic [1:0]    SEL_ACC   = 2'b00;
  localparam logic [1:0]    SEL_FLUSH = 2'b01;
  localparam logic [1:0]    SEL_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CLEAR  = 2'd2,
    STREAM = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [RW-1:0]    k_q;
  logic [RW-1:0]    wr_ptr_q;
  logic [RW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  logic [NumCols-1:0][OutDataWidth-1:0] data_mem [NumRows];
  logic [RW-1:0]                        tag_mem  [NumRows];

  function automatic logic [RW-1:0] next_ptr(input logic [RW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Outputs come straight from FIFO storage registers, never from col_acc_i.
  assign res_valid_o = (count_q != '0);
  assign pop         = res_valid_o & res_ready_i;
  assign res_data_o  = data_mem[rd_ptr_q];
  assign res_row_o   = tag_mem[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    acc_mux_sel_o = SEL_ACC;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    push          = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_mux_sel_o = SEL_FLUSH;
        push          = 1'b1;
        if (k_q == LAST_IDX) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        acc_mux_sel_o = SEL_CLEAR;
        state_d       = STREAM;
      end
      STREAM: begin
        // The last row may already have left during CLEAR when the sink never stalls.
        if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      k_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NumRows; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else begin
      state_q <= state_d;

      if ((state_q == SHIFT) && (k_q != LAST_IDX)) begin
        k_q <= k_q + 1'b1;
      end else begin
        k_q <= '0;
      end

      if (push) begin
        data_mem[wr_ptr_q] <= col_acc_i;
        tag_mem[wr_ptr_q]  <= LAST_IDX - k_q;
        wr_ptr_q           <= next_ptr(wr_ptr_q);
      end

      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end

      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_drain_ctrl.sv
`default_nettype none
// Bench for gemm_drain_ctrl: a directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_gemm_drain_ctrl;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int W   = 32;
  localparam int CKW = NC * W;

  typedef logic signed [NC-1:0][W-1:0] acc_t;
  typedef logic [CKW-1:0] ck_t;
  typedef struct {
    logic [1:0] row;
    acc_t       data;
  } ent_t;
  typedef struct {
    bit         st;
    bit         rdy;
    int         acc_row;
    logic [1:0] sel;
    bit         busy;
    bit         valid;
    int         row;
    bit         done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       start_i;
  acc_t       col_acc_i;
  logic [1:0] acc_mux_sel_o;
  acc_t       res_data_o;
  logic [1:0] res_row_o;
  logic       res_valid_o;
  logic       res_ready_i;
  logic       busy_o;
  logic       done_o;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  bit   active = 1'b0;
  int   j = 0;
  int   done_cnt = 0;
  int   popped[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  gemm_drain_ctrl #(
    .NumRows     (NR),
    .NumCols     (NC),
    .OutDataWidth(W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .col_acc_i    (col_acc_i),
    .acc_mux_sel_o(acc_mux_sel_o),
    .res_data_o   (res_data_o),
    .res_row_o    (res_row_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  function automatic acc_t row_acc(input int r);
    acc_t a;
    for (int c = 0; c < NC; c++) a[c] = W'(100 * r + c);
    return a;
  endfunction

  task automatic chk(input string name, input ck_t act, input ck_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: compare against the model at negedge, then advance the model at posedge.
  task automatic tick();
    bit         exp_valid, exp_done, do_pop, do_push, st_now;
    logic [1:0] exp_sel;
    acc_t       acc_now;
    ent_t       e;
    @(negedge clk);
    exp_valid = (q.size() != 0);
    exp_sel   = 2'b00;
    if (active && j <= NR) exp_sel = 2'b01;
    else if (active && j == NR + 1) exp_sel = 2'b11;
    exp_done = active && (j >= NR + 2) &&
               ((q.size() == 0) || ((q.size() == 1) && res_ready_i));
    chk("sel", ck_t'(acc_mux_sel_o), ck_t'(exp_sel));
    chk("busy", ck_t'(busy_o), ck_t'(active));
    chk("valid", ck_t'(res_valid_o), ck_t'(exp_valid));
    chk("done", ck_t'(done_o), ck_t'(exp_done));
    if (exp_valid) begin
      chk("row", ck_t'(res_row_o), ck_t'(q[0].row));
      chk("data", ck_t'(res_data_o), ck_t'(q[0].data));
    end
    if (done_o) done_cnt++;
    if (res_valid_o && res_ready_i) popped.push_back(int'(res_row_o));
    do_pop  = exp_valid && res_ready_i;
    do_push = active && (j <= NR);
    acc_now = col_acc_i;
    st_now  = start_i;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.row  = 2'(NR - j);
      e.data = acc_now;
      q.push_back(e);
    end
    if (exp_done) active = 1'b0;
    else if (active) j++;
    else if (st_now) begin
      active = 1'b1;
      j      = 1;
    end
    #1;
  endtask

  task automatic step(input bit st, input bit rdy, input acc_t acc);
    start_i     = st;
    res_ready_i = rdy;
    col_acc_i   = acc;
    tick();
  endtask

  task automatic apply_reset(input int cycles);
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    res_ready_i = 1'b0;
    col_acc_i   = '0;
    repeat (cycles) @(posedge clk);
    #1;
    q.delete();
    active = 1'b0;
    j      = 0;
    rst_ni = 1'b1;
    chk("rst_sel", ck_t'(acc_mux_sel_o), ck_t'(2'b00));
    chk("rst_valid", ck_t'(res_valid_o), ck_t'(1'b0));
    chk("rst_busy", ck_t'(busy_o), ck_t'(1'b0));
    chk("rst_done", ck_t'(done_o), ck_t'(1'b0));
    chk("rst_data", ck_t'(res_data_o), ck_t'(0));
    chk("rst_row", ck_t'(res_row_o), ck_t'(0));
  endtask

  task automatic check_order(input string name);
    chk({name, "_pops"}, ck_t'(popped.size()), ck_t'(NR));
    for (int i = 0; i < popped.size() && i < NR; i++)
      chk({name, "_order"}, ck_t'(popped[i]), ck_t'(NR - 1 - i));
  endtask

  initial begin
    acc_t neg;
    vecs[0] = '{1'b1, 1'b1, -1, 2'b00, 1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b1,  3, 2'b01, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b0, 1'b1,  2, 2'b01, 1'b1, 1'b1, 3, 1'b0};
    vecs[3] = '{1'b0, 1'b1,  1, 2'b01, 1'b1, 1'b1, 2, 1'b0};
    vecs[4] = '{1'b0, 1'b1,  0, 2'b01, 1'b1, 1'b1, 1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, -1, 2'b11, 1'b1, 1'b1, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, -1, 2'b00, 1'b1, 1'b0, 0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, -1, 2'b00, 1'b0, 1'b0, 0, 1'b0};

    apply_reset(2);

    // Full-throughput drain of a 100*r+c preloaded array.
    for (int i = 0; i < 8; i++) begin
      start_i     = vecs[i].st;
      res_ready_i = vecs[i].rdy;
      if (vecs[i].acc_row < 0) col_acc_i = '0;
      else col_acc_i = row_acc(vecs[i].acc_row);
      #1;
      chk("vec_sel", ck_t'(acc_mux_sel_o), ck_t'(vecs[i].sel));
      chk("vec_busy", ck_t'(busy_o), ck_t'(vecs[i].busy));
      chk("vec_valid", ck_t'(res_valid_o), ck_t'(vecs[i].valid));
      chk("vec_done", ck_t'(done_o), ck_t'(vecs[i].done));
      if (vecs[i].valid) begin
        chk("vec_row", ck_t'(res_row_o), ck_t'(vecs[i].row));
        chk("vec_data", ck_t'(res_data_o), ck_t'(row_acc(vecs[i].row)));
      end
      tick();
    end

    // Sink stalled for the whole drain, then released.
    done_cnt = 0;
    popped.delete();
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < NR; k++) step(1'b0, 1'b0, row_acc(NR - 1 - k));
    repeat (3) step(1'b0, 1'b0, '0);
    chk("stall_row_held", ck_t'(res_row_o), ck_t'(3));
    chk("stall_data_held", ck_t'(res_data_o), ck_t'(row_acc(3)));
    for (int k = 0; k < NR; k++) step(1'b0, 1'b1, '0);
    chk("stall_done_cnt", ck_t'(done_cnt), ck_t'(1));
    check_order("stall");
    step(1'b0, 1'b0, '0);

    // Alternating ready.
    done_cnt = 0;
    popped.delete();
    step(1'b1, 1'b1, '0);
    for (int i = 0; i < 12; i++)
      step(1'b0, (i % 2) == 0, (i < NR) ? row_acc(NR - 1 - i) : acc_t'(0));
    chk("toggle_done_cnt", ck_t'(done_cnt), ck_t'(1));
    check_order("toggle");

    // Second start mid-SHIFT is ignored.
    done_cnt = 0;
    step(1'b1, 1'b1, '0);
    step(1'b0, 1'b1, row_acc(3));
    step(1'b1, 1'b1, row_acc(2));
    step(1'b0, 1'b1, row_acc(1));
    step(1'b0, 1'b1, row_acc(0));
    repeat (5) step(1'b0, 1'b1, '0);
    chk("restart_done_cnt", ck_t'(done_cnt), ck_t'(1));

    // Clean follow-up drain with extreme negative values.
    done_cnt = 0;
    neg[0] = 32'hFFFF_FFFF;
    neg[1] = 32'h8000_0000;
    neg[2] = 32'h7FFF_FFFF;
    neg[3] = 32'hFFFF_FFFE;
    step(1'b1, 1'b1, '0);
    step(1'b0, 1'b1, neg);
    chk("neg_data", ck_t'(res_data_o), ck_t'({32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF}));
    for (int k = 1; k < NR; k++) step(1'b0, 1'b1, ~neg);
    repeat (3) step(1'b0, 1'b1, '0);
    chk("neg_done_cnt", ck_t'(done_cnt), ck_t'(1));

    // Reset during the second SHIFT cycle abandons the drain.
    done_cnt = 0;
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, row_acc(3));
    apply_reset(1);
    repeat (4) step(1'b0, 1'b1, '0);
    chk("abort_no_done", ck_t'(done_cnt), ck_t'(0));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset(1);
      end else begin
        acc_t a;
        for (int c = 0; c < NC; c++) begin
          a[c] = $urandom;
          if ($urandom_range(0, 7) == 0) a[c] = 32'h8000_0000;
        end
        step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, a);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gemm_drain_ctrl.md
GEMM_DRAIN_CTRL -- requirements
Module: gemm_drain_ctrl

Interface
REQ-001 SHALL have parameter NumRows, default 4, meaning PE rows in the output-stationary array (at least 1).
REQ-002 SHALL have parameter NumCols, default 4, meaning PE columns (at least 1).
REQ-003 SHALL have parameter OutDataWidth, default 32, meaning accumulator width per PE.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit: pulse requesting a drain of all accumulators.
REQ-007 SHALL have port col_acc_i, input, [NumCols-1:0][OutDataWidth-1:0] signed: acc_south of the bottom PE row, one per column.
REQ-008 SHALL have port acc_mux_sel_o, output, 2 bits: broadcast to every PE's acc_mux_sel (00 accumulate, 01 flush from north, 11 clear).
REQ-009 SHALL have port res_data_o, output, [NumCols-1:0][OutDataWidth-1:0] signed: one result row.
REQ-010 SHALL have port res_row_o, output, RW = max(1, $clog2(NumRows)) bits: array row index of res_data_o.
REQ-011 SHALL have port res_valid_o, output, 1 bit: res_data_o and res_row_o are valid.
REQ-012 SHALL have port res_ready_i, input, 1 bit: downstream accepts the current row.
REQ-013 SHALL have port busy_o, output, 1 bit: a drain is in progress.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse when the last row has been accepted.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT, CLEAR and STREAM.
REQ-016 In IDLE, start_i=1 SHALL move the FSM to SHIFT and load the shift counter k=0.
REQ-017 In SHIFT, acc_mux_sel_o SHALL be 01; each cycle SHALL write col_acc_i plus row tag NumRows-1-k into the buffer and increment k.
REQ-018 After the write with k=NumRows-1, the FSM SHALL go to CLEAR.
REQ-019 CLEAR SHALL last exactly 1 cycle with acc_mux_sel_o=11, then the FSM SHALL go to STREAM.
REQ-020 STREAM SHALL return to IDLE on the cycle the final buffered row handshakes; done_o SHALL be 1 in that same cycle.
REQ-021 acc_mux_sel_o SHALL be 00 in IDLE and STREAM.
REQ-022 The buffer SHALL be a FIFO of depth NumRows (write pointer, read pointer, count), so the first row out is array row NumRows-1 and the last is row 0.
REQ-023 res_valid_o SHALL equal (count != 0) in every state, so streaming overlaps SHIFT.
REQ-024 res_data_o and res_row_o SHALL present the FIFO head, registered, with no combinational path from col_acc_i.
REQ-025 A pop SHALL occur when res_valid_o=1 and res_ready_i=1.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged, with both pointers advancing.
REQ-027 Pointers SHALL wrap from NumRows-1 to 0.
REQ-028 Once res_valid_o=1, res_data_o and res_row_o SHALL hold stable until the handshake.
REQ-029 The FIFO SHALL never overflow: at most NumRows writes occur per drain and the FIFO is empty on entry to SHIFT.
REQ-030 busy_o SHALL be 1 in SHIFT, CLEAR and STREAM, and 0 in IDLE.
REQ-031 start_i SHALL be ignored while busy_o=1.
REQ-032 Latency: start_i sampled at edge t gives acc_mux_sel_o=01 for cycles t+1..t+NumRows, 11 at t+NumRows+1, and res_valid_o first high at t+2.
REQ-033 With res_ready_i held at 1, done_o SHALL pulse at cycle t+NumRows+2.
REQ-034 With NumRows=1, SHIFT SHALL last 1 cycle and res_row_o SHALL be 0.
REQ-035 Data SHALL pass through unmodified: no arithmetic and no sign change.

Reset
REQ-036 With rst_ni=0 at a clock edge, the next state SHALL be: FSM IDLE, k=0, pointers 0, count 0.
REQ-037 During that reset: acc_mux_sel_o=00, res_valid_o=0, busy_o=0, done_o=0, res_data_o=0, res_row_o=0.
REQ-038 Reset mid-drain SHALL abandon the drain and discard all buffered rows; no done_o pulse SHALL follow.

Verification
REQ-039 Scenario: NumRows=NumCols=4, PE (r,c) preloaded with 100*r+c, start_i pulse, res_ready_i=1 -> rows out in order 3,2,1,0; row 3 data {303,302,301,300}; sel_o 01x4 then 11x1; done_o at t+6.
REQ-040 Scenario: res_ready_i=0 throughout the drain -> count reaches 4, res_valid_o stays 1 with row 3 held stable; then ready=1 for 4 cycles -> 4 pops, done_o on the 4th.
REQ-041 Scenario: res_ready_i toggling 1,0,1,0... -> all 4 rows delivered exactly once, in order, with no loss or duplication.
REQ-042 Scenario: start_i pulsed again mid-SHIFT -> no effect; exactly one done_o; a second start after done_o runs a clean drain.
REQ-043 Scenario: rst_ni=0 for 1 cycle in the second SHIFT cycle -> next cycle IDLE, res_valid_o=0, sel_o=00, no done_o.
REQ-044 Scenario: negative accumulators (-1, -2147483648) -> res_data_o bit-exact.
